// File: rtl/cmp_event_tracker_if.sv
// Bundles the comparator sample stream and the tracker's registered results.
// The master side drives samples and clear; the slave side (the tracker) drives the results.
interface cmp_event_tracker_if #(
    parameter int CNT_W = 8
);
    logic             clear;
    logic             in_valid;
    logic [2:0]       cmp_code;
    logic [1:0]       state;
    logic             state_chg;
    logic             cross_up;
    logic             cross_dn;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic             err;

    modport master (
        output clear, in_valid, cmp_code,
        input  state, state_chg, cross_up, cross_dn, eq_cnt, gt_cnt, lt_cnt, err
    );

    modport slave (
        input  clear, in_valid, cmp_code,
        output state, state_chg, cross_up, cross_dn, eq_cnt, gt_cnt, lt_cnt, err
    );
endinterface

// File: rtl/cmp_event_tracker.sv
// Debounces the comparator's one-hot result into a relation state, counts each class
// with saturation, and pulses on state changes, rank crossings and illegal codes.
module cmp_event_tracker #(
    parameter int CNT_W   = 8,
    parameter int RUN_LEN = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    cmp_event_tracker_if.slave bus
);
    localparam int RUN_W = (RUN_LEN < 1) ? 1 : $clog2(RUN_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_TGT = RUN_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // The candidate reuses the state encoding, with IDLE meaning "no candidate".
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        EQUAL = 2'b01,
        ABOVE = 2'b10,
        BELOW = 2'b11
    } rel_e;

    rel_e             state_q, state_d, cand_q, cand_d, cls;
    logic [RUN_W-1:0] run_q, run_d, run_inc;
    logic [CNT_W-1:0] eq_q, gt_q, lt_q, eq_d, gt_d, lt_d;
    logic             chg_q, up_q, dn_q, err_q, chg_d, up_d, dn_d, err_d;
    logic             legal;

    function automatic logic [1:0] rank(input rel_e r);
        case (r)
            BELOW:   rank = 2'd0;
            EQUAL:   rank = 2'd1;
            ABOVE:   rank = 2'd2;
            default: rank = 2'd0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cand_q  <= IDLE;
            run_q   <= '0;
            eq_q    <= '0;
            gt_q    <= '0;
            lt_q    <= '0;
            chg_q   <= 1'b0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            run_q   <= run_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            chg_q   <= chg_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            err_q   <= err_d;
        end
    end

    // Illegal codes leave legal low, so they never touch the run in progress.
    always_comb begin
        legal = 1'b0;
        cls   = IDLE;
        case (bus.cmp_code)
            3'b001:  begin legal = bus.in_valid; cls = EQUAL; end
            3'b010:  begin legal = bus.in_valid; cls = ABOVE; end
            3'b100:  begin legal = bus.in_valid; cls = BELOW; end
            default: begin legal = 1'b0;         cls = IDLE;  end
        endcase
    end

    assign run_inc = run_q + RUN_W'(1);

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        run_d   = run_q;
        if (bus.clear) begin
            state_d = IDLE;
            cand_d  = IDLE;
            run_d   = '0;
        end else if (legal) begin
            if (cls == state_q) begin
                cand_d = IDLE;
                run_d  = '0;
            end else if (cls == cand_q && run_inc != RUN_TGT) begin
                run_d = run_inc;
            end else if (cls == cand_q || RUN_LEN == 1) begin
                state_d = cls;
                cand_d  = IDLE;
                run_d   = '0;
            end else begin
                cand_d = cls;
                run_d  = RUN_W'(1);
            end
        end
    end

    always_comb begin
        chg_d = !bus.clear && (state_d != state_q);
        up_d  = chg_d && (state_q != IDLE) && (rank(state_d) > rank(state_q));
        dn_d  = chg_d && (state_q != IDLE) && (rank(state_d) < rank(state_q));
        err_d = !bus.clear && bus.in_valid && !legal;
        eq_d  = eq_q;
        gt_d  = gt_q;
        lt_d  = lt_q;
        if (bus.clear) begin
            eq_d = '0;
            gt_d = '0;
            lt_d = '0;
        end else if (legal) begin
            if (cls == EQUAL && eq_q != CNT_MAX) eq_d = eq_q + CNT_W'(1);
            if (cls == ABOVE && gt_q != CNT_MAX) gt_d = gt_q + CNT_W'(1);
            if (cls == BELOW && lt_q != CNT_MAX) lt_d = lt_q + CNT_W'(1);
        end
    end

    assign bus.state     = state_q;
    assign bus.state_chg = chg_q;
    assign bus.cross_up  = up_q;
    assign bus.cross_dn  = dn_q;
    assign bus.err       = err_q;
    assign bus.eq_cnt    = eq_q;
    assign bus.gt_cnt    = gt_q;
    assign bus.lt_cnt    = lt_q;
endmodule
